// File: rtl/vga_sync_receiver_if.sv
// rtl/vga_sync_receiver_if.sv - sync pins and recovered timing of the VGA sync receiver
interface vga_sync_receiver_if;
    logic       hsync_in;
    logic       vsync_in;
    logic [9:0] x;
    logic [9:0] y;
    logic       de;
    logic       line_start;
    logic       frame_start;
    logic       locked;
    logic       err;
    logic [9:0] h_meas;
    logic [9:0] v_meas;
    logic [7:0] err_cnt;

    modport master (
        output hsync_in, vsync_in,
        input  x, y, de, line_start, frame_start, locked, err, h_meas, v_meas, err_cnt
    );

    modport slave (
        input  hsync_in, vsync_in,
        output x, y, de, line_start, frame_start, locked, err, h_meas, v_meas, err_cnt
    );
endinterface

// File: rtl/vga_sync_receiver.sv
// rtl/vga_sync_receiver.sv - VGA sync receiver: recovers x/y/de, checks mode timing, reports lock/err
// Define VGA_RX_STATS_EN to build the h_meas/v_meas/err_cnt statistics.
module vga_sync_receiver #(
    parameter int H_ACTIVE    = 640,
    parameter int H_FP        = 16,
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int V_ACTIVE    = 480,
    parameter int V_FP        = 10,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter bit HSYNC_POL   = 1'b0,
    parameter bit VSYNC_POL   = 1'b0,
    parameter int LOCK_FRAMES = 2
) (
    input logic                pclk,
    input logic                rst,
    vga_sync_receiver_if.slave vga
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;
    localparam int TMO      = 2 * H_TOTAL;
    localparam int TW       = $clog2(TMO + 1);

    typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_t;

    state_t        state_q, state_d;
    logic          hs1, hs2, vs1, vs2;
    logic          h_lead, h_trail, v_lead, v_trail, h_wrap;
    logic          mm_now, timeout, lose, locked;
    logic          mm_q, mm_d;
    logic [3:0]    good_q, good_d;
    logic [9:0]    hcnt, vcnt;
    logic [TW-1:0] tmo_cnt;
    logic          err_q;

    assign h_lead  = (hs1 == HSYNC_POL) && (hs2 != HSYNC_POL);
    assign h_trail = (hs1 != HSYNC_POL) && (hs2 == HSYNC_POL);
    assign v_lead  = (vs1 == VSYNC_POL) && (vs2 != VSYNC_POL);
    assign v_trail = (vs1 != VSYNC_POL) && (vs2 == VSYNC_POL);
    assign h_wrap  = (hcnt == 10'(H_TOTAL - 1));
    assign timeout = !(h_lead || h_trail) && (tmo_cnt == TW'(TMO - 1));

    // Counters lag the pins by one cycle, so each edge must land on its nominal count.
    assign mm_now = (h_lead  && (hcnt != 10'(HS_START)))
                 || (h_trail && (hcnt != 10'(HS_END)))
                 || (v_lead  && ((vcnt != 10'(VS_START)) || (hcnt != 10'd0)))
                 || (v_trail && (vcnt != 10'(VS_END)));

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            hs1     <= 1'b0;
            hs2     <= 1'b0;
            vs1     <= 1'b0;
            vs2     <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            tmo_cnt <= '0;
        end else begin
            hs1 <= vga.hsync_in;
            hs2 <= hs1;
            vs1 <= vga.vsync_in;
            vs2 <= vs1;
            if (h_lead)
                hcnt <= 10'(HS_START + 1);
            else if (h_wrap)
                hcnt <= '0;
            else
                hcnt <= hcnt + 10'd1;
            if (v_lead)
                vcnt <= 10'(VS_START);
            else if (h_wrap)
                vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
            if (h_lead || h_trail || timeout)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        good_d  = good_q;
        mm_d    = mm_q | mm_now;
        lose    = 1'b0;
        if (timeout) begin
            state_d = SEARCH;
            lose    = (state_q == LOCKED);
        end else begin
            case (state_q)
                SEARCH: begin
                    if (v_lead) begin
                        state_d = CHECK;
                        good_d  = '0;
                        mm_d    = 1'b0;
                    end
                end
                CHECK: begin
                    if (v_lead) begin
                        mm_d = 1'b0;
                        if (mm_q || mm_now) begin
                            state_d = SEARCH;
                        end else begin
                            good_d = good_q + 4'd1;
                            if (good_q + 4'd1 == 4'(LOCK_FRAMES))
                                state_d = LOCKED;
                        end
                    end
                end
                LOCKED: begin
                    if (mm_now) begin
                        state_d = SEARCH;
                        lose    = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            state_q <= SEARCH;
            good_q  <= '0;
            mm_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            good_q  <= good_d;
            mm_q    <= mm_d;
            if (lose)
                err_q <= 1'b1;
        end
    end

    assign locked          = (state_q == LOCKED);
    assign vga.locked      = locked;
    assign vga.err         = err_q;
    assign vga.x           = hcnt;
    assign vga.y           = vcnt;
    assign vga.de          = locked && (hcnt < 10'(H_ACTIVE)) && (vcnt < 10'(V_ACTIVE));
    assign vga.line_start  = locked && (hcnt == 10'd0) && (vcnt < 10'(V_ACTIVE));
    assign vga.frame_start = locked && (hcnt == 10'd0) && (vcnt == 10'd0);

`ifdef VGA_RX_STATS_EN
    logic [9:0] h_per, v_per, h_meas_q, v_meas_q;
    logic [7:0] err_cnt_q;

    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            h_per     <= '0;
            v_per     <= '0;
            h_meas_q  <= '0;
            v_meas_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            if (h_lead) begin
                h_meas_q <= h_per;
                h_per    <= 10'd1;
            end else if (h_per != 10'h3ff) begin
                h_per <= h_per + 10'd1;
            end
            if (v_lead) begin
                v_meas_q <= v_per;
                v_per    <= {9'd0, h_wrap};
            end else if (h_wrap && (v_per != 10'h3ff)) begin
                v_per <= v_per + 10'd1;
            end
            if (lose && (err_cnt_q != 8'hff))
                err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign vga.h_meas  = h_meas_q;
    assign vga.v_meas  = v_meas_q;
    assign vga.err_cnt = err_cnt_q;
`else
    assign vga.h_meas  = '0;
    assign vga.v_meas  = '0;
    assign vga.err_cnt = '0;
`endif
endmodule
